shift_unit: RTL
===============

SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; power of two, 8 to 64.
REQ-002 SHALL have parameter AMT_W, default 32, width of the shift_amount port.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port op, input, 3, operation: 0 SHR logical, 1 SHRA arithmetic, 2 SHL, 3 ROR, 4 ROL, 5-7 pass-through.
REQ-008 SHALL have port data_in, input, WIDTH, operand.
REQ-009 SHALL have port shift_amount, input, AMT_W, amount, treated as unsigned.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port data_out, output, WIDTH, result.
REQ-013 SHALL have port zero, output, 1, high when data_out is all zeros while out_valid is high.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 SHALL capture op, data_in and shift_amount on the rising edge where in_valid and in_ready are both 1, then go to SHIFT with stage counter = 0.
REQ-016 SHALL, in SHIFT, apply on each edge stage k: shift or rotate by 2^k if bit k of the effective amount is 1, else pass; SHALL increment k and go to DONE after stage S-1, where S = log2(WIDTH).
REQ-017 SHALL have fixed latency: out_valid rises exactly S cycles after the accepting edge (5 cycles at WIDTH=32), independent of amount and op.
REQ-018 SHALL use effective amount = shift_amount mod WIDTH for ROR and ROL.
REQ-019 SHALL, for SHR, SHL and SHRA with shift_amount >= WIDTH, produce all zeros (SHR, SHL) or all copies of data_in[WIDTH-1] (SHRA); latency is unchanged.
REQ-020 SHALL return data_in unchanged for op 5-7 and for shift_amount = 0.
REQ-021 SHALL hold data_out, zero and out_valid stable in DONE until out_ready = 1 at an edge; then go to IDLE, with in_ready = 1 the following cycle (no same-cycle turnaround).
REQ-022 SHALL ignore in_valid outside IDLE; captured operands SHALL NOT change during SHIFT or DONE.
REQ-023 SHALL drive data_out = 0 and zero = 0 whenever out_valid = 0.

Reset
REQ-024 SHALL, while rst_n = 0 and regardless of clk, force state IDLE, in_ready 1, out_valid 0, data_out 0, zero 0 and stage counter 0.
REQ-025 SHALL discard any in-flight operation on reset mid-SHIFT or mid-DONE; no result SHALL appear after release.
REQ-026 SHALL accept a request on the first rising edge after rst_n deasserts.

Structure
REQ-027 SHALL place op encodings (OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL) and FSM state encodings in shared package shift_pkg.
REQ-028 SHALL implement one stage as combinational sub-module shift_stage (inputs: value, op, stage index, enable bit); it SHALL be used once, muxed by the stage counter.
REQ-029 SHALL compute the saturate decision (REQ-019) once at capture and store it as a flag.

Verification
REQ-030 Bench SHALL apply op=SHR, data_in=6, amount=1: data_out=3; out_valid exactly 5 cycles after accept (WIDTH=32); also data_in=5, amount=3: data_out=0, zero=1.
REQ-031 Bench SHALL apply op=SHRA, data_in=0xF0000000, amount=4: data_out=0xFF000000; amount=40: data_out=0xFFFFFFFF; amount=0xFFFFFFFF: data_out=0xFFFFFFFF.
REQ-032 Bench SHALL apply op=ROL, data_in=0x80000001, amount=1: data_out=0x00000003; op=ROR, data_in=0x00000001, amount=33: data_out=0x80000000.
REQ-033 Bench SHALL apply op=SHL, data_in=5, amount=3: data_out=40; op=6, data_in=0x1234: data_out=0x1234.
REQ-034 Bench SHALL hold out_ready=0 for 3 cycles in DONE with in_valid=1 and new operands: data_out stable, in_ready=0, new request accepted only after handoff.
REQ-035 Bench SHALL pulse rst_n low at SHIFT stage 2: out_valid=0 immediately, in_ready=1 and no result after release, and the next request completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
//==========================================================================
// shift_pkg -- op and FSM state encodings shared by the shift unit (rev 1.0)
//==========================================================================
`default_nettype none

package shift_pkg;

  localparam logic [2:0] OP_SHR  = 3'd0;
  localparam logic [2:0] OP_SHRA = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/shift_stage.sv
//==========================================================================
// shift_stage -- one combinational log-shifter stage, distance 2^stage (rev 1.0)
//==========================================================================
`default_nettype none

module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [2:0]       op_i,
  input  logic [SW-1:0]    stage_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] value_o
);

  logic [SW:0] w_dist;
  logic [SW:0] w_comp;

  // Distance never exceeds WIDTH/2, so the rotate complement stays in range.
  assign w_dist = (SW+1)'(1) << stage_i;
  assign w_comp = (SW+1)'(WIDTH) - w_dist;

  always_comb begin
    value_o = value_i;
    if (en_i) begin
      case (op_i)
        OP_SHR:  value_o = value_i >> w_dist;
        OP_SHRA: value_o = $unsigned($signed(value_i) >>> w_dist);
        OP_SHL:  value_o = value_i << w_dist;
        OP_ROR:  value_o = (value_i >> w_dist) | (value_i << w_comp);
        OP_ROL:  value_o = (value_i << w_dist) | (value_i >> w_comp);
        default: value_o = value_i;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_unit.sv
//==========================================================================
// shift_unit -- multi-cycle shifter/rotator, one log stage per clock (rev 1.0)
//==========================================================================
`default_nettype none

module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shift_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             zero
);

  localparam int            SW         = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST_STAGE = SW'(SW - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [SW-1:0]    amt_q,   amt_d;
  logic [2:0]       op_q,    op_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             sat_q,   sat_d;

  logic             w_is_shift;
  logic             w_big;
  logic [WIDTH-1:0] w_stage_val;
  logic [WIDTH-1:0] w_result;

  assign w_is_shift = (op == OP_SHR) || (op == OP_SHRA) || (op == OP_SHL);
  assign w_big      = (shift_amount >> SW) != '0;

  shift_stage #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_stage (
    .value_i (data_q),
    .op_i    (op_q),
    .stage_i (stage_q),
    .en_i    (amt_q[stage_q]),
    .value_o (w_stage_val)
  );

  // A saturated request keeps data_q untouched so its sign bit supplies the SHRA fill.
  assign w_result = sat_q ? ((op_q == OP_SHRA && data_q[WIDTH-1]) ? '1 : '0) : data_q;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    amt_d   = amt_q;
    op_d    = op_q;
    data_d  = data_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = op;
          data_d  = data_in;
          sat_d   = w_big && w_is_shift;
          amt_d   = (w_big && w_is_shift) ? '0 : shift_amount[SW-1:0];
          stage_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d  = w_stage_val;
        stage_d = stage_q + 1'b1;
        if (stage_q == LAST_STAGE) begin
          stage_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign data_out  = out_valid ? w_result : '0;
  assign zero      = out_valid && (w_result == '0);

endmodule

`default_nettype wire
